// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Imported by pc_target_calc and pc_sequencer.
package pc_seq_pkg;

  localparam int          DATA_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } seq_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    EX_BR = 2'd1,
    ID_JR = 2'd2,
    ID_J  = 2'd3
  } redir_src_e;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target computation and priority select (EX branch > ID jr > ID jump).
// Purely combinational; id_en gates the decode-stage requests.
module pc_target_calc
  import pc_seq_pkg::*;
(
  input  logic              ex_br_taken,
  input  logic [DATA_W-1:0] ex_br_pc,
  input  logic [DATA_W-1:0] ex_br_off,
  input  logic              id_en,
  input  logic              id_jump,
  input  logic [25:0]       id_jump_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              id_jr,
  input  logic [DATA_W-1:0] id_jr_target,
  output logic              redirect_valid,
  output redir_src_e        redirect_src,
  output logic [DATA_W-1:0] target
);

  logic signed [DATA_W-1:0] br_off_sh;
  logic        [DATA_W-1:0] br_target;
  logic        [DATA_W-1:0] j_target;

  // Offset is already sign-extended, so an arithmetic shift keeps negative displacements intact.
  assign br_off_sh = $signed(ex_br_off) <<< 2;
  assign br_target = ex_br_pc + PC_STEP + $unsigned(br_off_sh);

  // Region bits come from the delay-slot PC, the low 28 bits from the instruction index.
  assign j_target  = ((id_pc + PC_STEP) & 32'hF000_0000) | {4'b0000, id_jump_imm, 2'b00};

  always_comb begin
    redirect_valid = 1'b0;
    redirect_src   = NONE;
    target         = '0;
    if (ex_br_taken) begin
      redirect_valid = 1'b1;
      redirect_src   = EX_BR;
      target         = br_target;
    end else if (id_en && id_jr) begin
      redirect_valid = 1'b1;
      redirect_src   = ID_JR;
      target         = id_jr_target;
    end else if (id_en && id_jump) begin
      redirect_valid = 1'b1;
      redirect_src   = ID_J;
      target         = j_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: fetch handshake, redirects, IF/ID and ID/EX flush pulses.
// Build option PC_SEQ_DELAY_SLOT_EN selects MIPS delay-slot redirect semantics.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  output logic        if_valid,
  output logic [31:0] pc_out,
  input  logic        stall,
  input  logic        id_jump,
  input  logic [25:0] id_jump_imm,
  input  logic [31:0] id_pc,
  input  logic        id_jr,
  input  logic [31:0] id_jr_target,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_pc,
  input  logic [31:0] ex_br_off,
  output logic        flush_ifid,
  output logic        flush_idex
);

`ifdef PC_SEQ_DELAY_SLOT_EN
  localparam logic EX_FLUSH_IDEX = 1'b0;
  localparam logic ID_FLUSH_IFID = 1'b0;
  localparam logic ID_KEEP       = 1'b1;
`else
  localparam logic EX_FLUSH_IDEX = 1'b1;
  localparam logic ID_FLUSH_IFID = 1'b1;
  localparam logic ID_KEEP       = 1'b0;
`endif

  seq_state_e  state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pending, pending_n;
  logic        keep, keep_n;

  logic        id_en;
  logic        redirect_valid;
  redir_src_e  redirect_src;
  logic [31:0] target;
  logic        src_ex;

  // Decode-stage redirects only count in FETCH and when the hazard unit is not freezing ID.
  assign id_en  = (state == FETCH) && !stall;
  assign src_ex = (redirect_src == EX_BR);

  pc_target_calc u_target_calc (
    .ex_br_taken   (ex_br_taken),
    .ex_br_pc      (ex_br_pc),
    .ex_br_off     (ex_br_off),
    .id_en         (id_en),
    .id_jump       (id_jump),
    .id_jump_imm   (id_jump_imm),
    .id_pc         (id_pc),
    .id_jr         (id_jr),
    .id_jr_target  (id_jr_target),
    .redirect_valid(redirect_valid),
    .redirect_src  (redirect_src),
    .target        (target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HOLD;
      pc      <= RESET_PC;
      pending <= '0;
      keep    <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pending <= pending_n;
      keep    <= keep_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pending_n  = pending;
    keep_n     = keep;
    if_req     = 1'b0;
    if_valid   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;

    unique case (state)
      HOLD: begin
        state_n = FETCH;
      end

      FETCH: begin
        if_req = 1'b1;
        if (redirect_valid) begin
          flush_ifid = src_ex ? 1'b1 : ID_FLUSH_IFID;
          flush_idex = src_ex ? EX_FLUSH_IDEX : 1'b0;
          if (if_ack) begin
            pc_n = target;
          end else begin
            // The in-flight fetch must complete at the old address before the PC can move.
            pending_n = target;
            keep_n    = src_ex ? 1'b0 : ID_KEEP;
            state_n   = DRAIN;
          end
        end else if (if_ack && !stall) begin
          pc_n = pc + PC_STEP;
        end
        if_valid = if_ack && !stall && !flush_ifid;
      end

      DRAIN: begin
        if_req = 1'b1;
        if (redirect_valid) begin
          // A later EX branch supersedes the parked target and kills the draining fetch.
          flush_ifid = 1'b1;
          flush_idex = EX_FLUSH_IDEX;
          keep_n     = 1'b0;
          if (if_ack) begin
            pc_n    = target;
            state_n = FETCH;
          end else begin
            pending_n = target;
          end
        end else if (if_ack) begin
          if_valid = keep && !stall;
          pc_n     = pending;
          keep_n   = 1'b0;
          state_n  = FETCH;
        end
      end

      default: begin
        state_n = HOLD;
      end
    endcase
  end

  assign if_addr = pc;
  assign pc_out  = pc;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage program-counter sequencer for the five-stage pipeline. Holds the PC, issues fetch requests to instruction memory over a valid/ack handshake, and applies redirects from the decode stage (j/jal/jr) and the execute stage (taken branch) using the shift-left-2 and jump-concatenation target forms. Generates the IF/ID and ID/EX flush pulses. Sits between the hazard unit, ID/EX control, and instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  out  1  fetch request valid
- if_addr  out  32  fetch address; stable while if_req && !if_ack
- if_ack  in  1  imem accepts and returns the instruction this cycle
- if_valid  out  1  returned instruction may be loaded into IF/ID
- pc_out  out  32  current PC register (equals if_addr)
- stall  in  1  hazard freeze of PC and IF/ID
- id_jump  in  1  j/jal in ID
- id_jump_imm  in  26  instr_index of that jump
- id_pc  in  32  PC of the instruction in ID
- id_jr  in  1  jr in ID
- id_jr_target  in  32  forwarded rs value
- ex_br_taken  in  1  branch in EX resolved taken
- ex_br_pc  in  32  PC of that branch
- ex_br_off  in  32  sign-extended 16-bit offset
- flush_ifid  out  1  IF/ID loads bubble this cycle
- flush_idex  out  1  ID/EX loads bubble this cycle

## Operation
- States: HOLD, FETCH, DRAIN.
- HOLD: entered on reset; if_req=0. Next cycle goes to FETCH.
- FETCH: if_req=1. Target and PC arithmetic is mod 2^32.
  - Branch target: ex_br_pc + 4 + (ex_br_off << 2).
  - Jump target: {(id_pc+4)[31:28], id_jump_imm, 2'b00}.
  - jr target: id_jr_target, used unmodified.
- Redirect priority: EX branch > ID jr > ID jump. ID redirects are ignored while stall=1. EX redirect is honoured regardless of stall.
- Redirect with if_ack=1: pc <= target; stay in FETCH.
- Redirect with if_ack=0: save the target in a pending register and set keep = (delay-slot rule below); go to DRAIN.
- No redirect, if_ack && !stall: pc <= pc+4. Wrap-around from 32'hFFFF_FFFC goes to 0.
- if_valid (FETCH) = if_ack && !stall && !flush_ifid.
- DRAIN: if_req=1 with the old if_addr until if_ack.
  - On if_ack: if_valid=keep && !stall, pc <= pending, go to FETCH.
  - ID redirects are ignored in DRAIN.
  - An EX redirect in DRAIN overwrites pending, clears keep, and pulses the flushes.
- Flushes are single-cycle pulses in the redirect cycle.
- Reset mid-operation, including in DRAIN: pending is discarded and all state is cleared immediately.

## Timing
- Reset values: state=HOLD, pc=RESET_PC, pending=0, keep=0. Outputs: if_req=0, if_valid=0, flush_ifid=0, flush_idex=0, if_addr=pc_out=RESET_PC.
- First if_req occurs on the first clk edge after rst_n rises.
- With if_ack tied to 1: one fetch per cycle, and the redirect target appears on if_addr the cycle after the redirect.
- The flush outputs and if_valid are combinational in the redirect/ack cycle. The PC and state update at the next edge.

## Configuration
- Macro: PC_SEQ_DELAY_SLOT_EN.
- Defined (MIPS delay slot):
  - ID jump/jr: flush_ifid=0, keep=1. The fetched instruction is the delay slot.
  - EX branch: flush_ifid=1, flush_idex=0. The ID instruction is the delay slot.
- Undefined:
  - ID jump/jr: flush_ifid=1, keep=0.
  - EX branch: flush_ifid=1, flush_idex=1.

## Structure
- Package pc_seq_pkg contains:
  - the state enum (HOLD/FETCH/DRAIN)
  - the redirect-source enum (NONE/EX_BR/ID_JR/ID_J)
  - the default RESET_PC
  - the constant PC_STEP=4
- Sub-module pc_target_calc: combinational. Computes the branch adder, the jump concatenation, and the priority mux. Outputs redirect_valid, the redirect source, and the target.

## Test plan
- Reset release with if_ack=1: if_addr sequence 0, 4, 8, 12 on consecutive cycles; if_valid=1 each cycle.
- ex_br_taken with ex_br_pc=0x40, ex_br_off=0xFFFF_FFFE, delay slot off: target 0x3C next cycle; flush_ifid=flush_idex=1 for one cycle.
- id_jump with id_pc=0x1000_0010, imm=0x0000_100: next if_addr=0x1000_0400. flush_ifid is 1 without the macro and 0 with it.
- Same-cycle ex_br_taken (target 0x80) and id_jr (target 0x200): if_addr=0x80; ID redirect dropped.
- if_ack=0 for 3 cycles at addr 0x8 with id_jump to 0x100, delay slot off: if_addr held at 0x8; then ack with if_valid=0; then if_addr=0x100.
- rst_n pulsed low while in DRAIN: outputs return to reset values within the same cycle; fetch restarts at RESET_PC.
